// File: rtl/gpio_bank_pkg.sv
// gpio_bank_pkg: config bit positions, width and reset value shared by the GPIO bank.
package gpio_bank_pkg;
    localparam int CFG_W = 4;
    localparam int CFG_DIR = 0;
    localparam int CFG_OREG = 1;
    localparam int CFG_ISYNC = 2;
    localparam int CFG_INV = 3;
    typedef logic [CFG_W-1:0] cfg_t;
    localparam cfg_t CFG_RST = 4'b0000;
endpackage

// File: rtl/gpio_pad_cell.sv
// gpio_pad_cell: one pad's config register, output register, input synchroniser, invert and edge detector.
// clk/pReset: clock, async active-high reset. we/wdata: config write. cfg: current config word.
// outpad: fabric output data. pad_i: raw pad value. pad_oe/pad_o: tristate control. inpad/rise: conditioned input and its rising-edge pulse.
module gpio_pad_cell
    import gpio_bank_pkg::*;
(
    input  logic clk,
    input  logic pReset,
    input  logic we,
    input  cfg_t wdata,
    input  logic outpad,
    input  logic pad_i,
    output cfg_t cfg,
    output logic pad_oe,
    output logic pad_o,
    output logic inpad,
    output logic rise
);
    logic oreg_q, s1, s2, e_q, cond;
    always_ff @(posedge clk or posedge pReset)
        if (pReset) begin
            cfg <= CFG_RST;
            oreg_q <= 1'b0;
            s1 <= 1'b0;
            s2 <= 1'b0;
            e_q <= 1'b0;
        end else begin
            if (we) cfg <= wdata;
            oreg_q <= outpad;
            s1 <= pad_i;
            s2 <= s1;
            e_q <= inpad;
        end
    assign pad_oe = cfg[CFG_DIR];
    assign pad_o = cfg[CFG_OREG] ? oreg_q : outpad;
    assign cond = cfg[CFG_ISYNC] ? s2 : pad_i;
    // Pads may be driven externally during reset, so the fabric view is forced low explicitly.
    assign inpad = !pReset && (cond ^ cfg[CFG_INV]);
    assign rise = inpad & ~e_q;
endmodule

// File: rtl/logical_tile_gpio_bank.sv
// logical_tile_gpio_bank: bank of NUM_PADS configurable bidirectional GPIO pads with per-pad config words.
// clk/pReset: clock, async active-high reset. gfpga_pad_GPIO_PAD: physical pads. io_outpad: fabric drive data.
// enable/address/data_in: config write port. cfg_rdata: config of pad[address]. io_inpad/io_edge: fabric input data and rising-edge pulses.
module logical_tile_gpio_bank #(
    parameter int NUM_PADS = 4,
    parameter int ADDR_W = 2,
    parameter int CFG_W = gpio_bank_pkg::CFG_W
) (
    input  logic                clk,
    input  logic                pReset,
    inout  wire  [NUM_PADS-1:0] gfpga_pad_GPIO_PAD,
    input  logic [NUM_PADS-1:0] io_outpad,
    input  logic                enable,
    input  logic [ADDR_W-1:0]   address,
    input  logic [CFG_W-1:0]    data_in,
    output logic [CFG_W-1:0]    cfg_rdata,
    output logic [NUM_PADS-1:0] io_inpad,
    output logic [NUM_PADS-1:0] io_edge
);
    logic [CFG_W-1:0] cfg [NUM_PADS];
    for (genvar g = 0; g < NUM_PADS; g++) begin : g_pad
        logic oe, o;
        gpio_pad_cell u_cell (
            .clk(clk),
            .pReset(pReset),
            .we(enable && int'(address) == g),
            .wdata(data_in),
            .outpad(io_outpad[g]),
            .pad_i(gfpga_pad_GPIO_PAD[g]),
            .cfg(cfg[g]),
            .pad_oe(oe),
            .pad_o(o),
            .inpad(io_inpad[g]),
            .rise(io_edge[g])
        );
        assign gfpga_pad_GPIO_PAD[g] = oe ? o : 1'bz;
    end
    assign cfg_rdata = int'(address) < NUM_PADS ? cfg[address] : '0;
endmodule

// File: tb/tb_logical_tile_gpio_bank.sv
// tb_logical_tile_gpio_bank: directed and randomized checks of the GPIO bank against a cycle model.
module tb_logical_tile_gpio_bank;
    localparam int N = 3, AW = 2, CW = 4;
    logic clk = 0, rst = 1;
    logic [N-1:0] outpad = '0, ext_en = '1, ext_val = '0;
    logic enable = 0;
    logic [AW-1:0] address = '0;
    logic [CW-1:0] data_in = '0;
    wire [N-1:0] pad;
    logic [CW-1:0] cfg_rdata;
    logic [N-1:0] io_inpad, io_edge;
    int errors = 0, checks = 0;
    logic [CW-1:0] m_cfg [N];
    logic [N-1:0] m_out_prev, m_raw1, m_raw2, m_in_prev;
    logic [N-1:0] x_raw, x_in, x_edge;
    logic [CW-1:0] x_rd;

    always #5 clk = ~clk;
    for (genvar g = 0; g < N; g++) assign pad[g] = ext_en[g] ? ext_val[g] : 1'bz;

    logical_tile_gpio_bank #(.NUM_PADS(N), .ADDR_W(AW), .CFG_W(CW)) dut (
        .clk(clk),
        .pReset(rst),
        .gfpga_pad_GPIO_PAD(pad),
        .io_outpad(outpad),
        .enable(enable),
        .address(address),
        .data_in(data_in),
        .cfg_rdata(cfg_rdata),
        .io_inpad(io_inpad),
        .io_edge(io_edge)
    );

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask

    // Expected pad/input/edge/readback values for the current inputs, from the model's history.
    task automatic eval();
        logic [CW-1:0] c;
        logic v, s;
        for (int i = 0; i < N; i++) ext_en[i] = rst || !m_cfg[i][0];
        #1;
        for (int i = 0; i < N; i++) begin
            c = rst ? '0 : m_cfg[i];
            v = c[1] ? m_out_prev[i] : outpad[i];
            x_raw[i] = c[0] ? v : ext_val[i];
            s = c[2] ? m_raw2[i] : x_raw[i];
            x_in[i] = !rst && (s ^ c[3]);
        end
        x_edge = x_in & ~m_in_prev;
        x_rd = (!rst && int'(address) < N) ? m_cfg[address] : '0;
        chk("pad", 32'(pad), 32'(x_raw));
        chk("io_inpad", 32'(io_inpad), 32'(x_in));
        chk("io_edge", 32'(io_edge), 32'(x_edge));
        chk("cfg_rdata", 32'(cfg_rdata), 32'(x_rd));
    endtask

    task automatic adv();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < N; i++) m_cfg[i] = '0;
            m_out_prev = '0; m_raw1 = '0; m_raw2 = '0; m_in_prev = '0;
        end else begin
            if (enable && int'(address) < N) m_cfg[address] = data_in;
            m_out_prev = outpad; m_raw2 = m_raw1; m_raw1 = x_raw; m_in_prev = x_in;
        end
        @(negedge clk);
    endtask

    task automatic step();
        eval();
        adv();
    endtask

    initial begin
        for (int i = 0; i < N; i++) m_cfg[i] = '0;
        m_out_prev = '0; m_raw1 = '0; m_raw2 = '0; m_in_prev = '0;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            outpad = N'($urandom); ext_val = N'($urandom); address = AW'(k);
            eval();
            chk("rst_inpad", 32'(io_inpad), 0);
            chk("rst_edge", 32'(io_edge), 0);
            chk("rst_rdata", 32'(cfg_rdata), 0);
            chk("rst_float", 32'(pad), 32'(ext_val));
            adv();
        end
        rst = 0; outpad = '0; ext_val = '0;
        step();
        enable = 1; address = 2; data_in = 4'b0001; outpad = 3'b100; ext_val = 3'b010;
        eval();
        chk("wr_old_rd", 32'(cfg_rdata), 0);
        adv();
        enable = 0;
        eval();
        chk("pad2_drive", 32'(pad[2]), 1);
        chk("pad2_rd", 32'(cfg_rdata), 1);
        chk("pad10_float", 32'(pad[1:0]), 2);
        adv();
        outpad = 3'b000;
        eval();
        chk("pad2_comb", 32'(pad[2]), 0);
        adv();
        enable = 1; address = 1; data_in = 4'b0011; ext_val = 3'b000;
        step();
        enable = 0; outpad = 3'b010;
        eval();
        chk("oreg_n", 32'(pad[1]), 0);
        adv();
        eval();
        chk("oreg_n1", 32'(pad[1]), 1);
        adv();
        enable = 1; address = 1; data_in = 4'b0010;
        eval();
        chk("dir_off_same", 32'(pad[1]), 1);
        adv();
        enable = 0;
        eval();
        chk("dir_off_next", 32'(pad[1]), 0);
        adv();
        enable = 1; address = 0; data_in = 4'b0100; ext_val = 3'b000;
        step();
        enable = 0;
        step();
        step();
        ext_val[0] = 1;
        eval();
        chk("sync_n", 32'(io_inpad[0]), 0);
        adv();
        eval();
        chk("sync_n1", 32'(io_inpad[0]), 0);
        chk("sync_e1", 32'(io_edge[0]), 0);
        adv();
        eval();
        chk("sync_n2", 32'(io_inpad[0]), 1);
        chk("sync_e2", 32'(io_edge[0]), 1);
        adv();
        eval();
        chk("sync_e3", 32'(io_edge[0]), 0);
        adv();
        ext_val[0] = 0; enable = 1; address = 0; data_in = 4'b1100;
        step();
        enable = 0;
        for (int k = 0; k < 4; k++) step();
        ext_val[0] = 1;
        eval();
        chk("inv_n", 32'({io_inpad[0], io_edge[0]}), 2);
        adv();
        eval();
        chk("inv_n1", 32'({io_inpad[0], io_edge[0]}), 2);
        adv();
        eval();
        chk("inv_n2", 32'({io_inpad[0], io_edge[0]}), 0);
        adv();
        eval();
        chk("inv_n3", 32'(io_edge[0]), 0);
        adv();
        enable = 1; address = 3; data_in = 4'hF;
        eval();
        chk("bad_addr_rd", 32'(cfg_rdata), 0);
        adv();
        enable = 0;
        for (int a = 0; a < 4; a++) begin
            address = AW'(a);
            eval();
            chk("rd_after_bad", 32'(cfg_rdata), a == 0 ? 32'hC : a == 1 ? 32'h2 : a == 2 ? 32'h1 : 0);
            adv();
        end
        enable = 1; data_in = 4'b0001;
        for (int a = 0; a < N; a++) begin
            address = AW'(a);
            step();
        end
        enable = 0; outpad = 3'b111;
        eval();
        chk("all_drive", 32'(pad), 7);
        adv();
        rst = 1; ext_val = 3'b000;
        eval();
        chk("rst_mid_float", 32'(pad), 0);
        chk("rst_mid_inpad", 32'(io_inpad), 0);
        adv();
        rst = 0;
        for (int k = 0; k < 3000; k++) begin
            rst = $urandom_range(99) == 0;
            enable = 1'($urandom);
            address = AW'($urandom);
            data_in = CW'($urandom);
            outpad = N'($urandom);
            ext_val = N'($urandom);
            step();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
